main_memory_ctrl: RTL and testbench
===================================

// Module: main_memory_ctrl
// PURPOSE
//  Word-addressed main-memory model/controller directly downstream of the L1 data cache.
//  Serves 8-word line fills on cache load misses and single-word stores using VALID/READY plus
//  per-word index acknowledges. Buses are split; there are no tristates. Single clock domain.
// PARAMETERS
//  MEM_WORDS       1024  storage depth in 32-bit words (power of 2); index = address mod MEM_WORDS
//  WORDS_PER_LINE  8     burst length of a line fill; line base = {addr[31:3],3'b000}
//  RD_LATENCY      2     idle cycles between address capture and first fill word (0..15)
// PORTS
//  CLK           in   1   clock; all logic on posedge
//  RST_N         in   1   synchronous active-low reset
//  VALID         in   1   L1 request active; held high for the whole transaction
//  STORE         in   1   1 = store, 0 = load/line fill; sampled with ACK_ADDR
//  ADDR_IN       in   32  word address; meaningful while ACK_ADDR=1
//  ACK_ADDR      in   1   L1 asserts: ADDR_IN is valid
//  WDATA         in   32  store data
//  ACK_DATA_L1   in   4   L1 ack/present index; 4'hF = none
//  READY         out  1   memory ready to handshake
//  RDATA         out  32  fill word being presented
//  ACK_DATA_MEM  out  4   index of word on RDATA (load) / store-done tag 4'h0; 4'hF = none
//  BUSY          out  1   FSM not in IDLE
// BEHAVIOUR
//  Reset (RST_N=0 at posedge): READY=0, RDATA=0, ACK_DATA_MEM=4'hF, BUSY=0, FSM->IDLE, counters=0.
//   Storage contents are not cleared. Reset mid-transaction aborts it. No write occurs that cycle.
//  FSM states: IDLE, ADDR, WAIT, BURST, SWR, DONE.
//  IDLE : VALID=1 -> ADDR next cycle (BUSY=1).
//  ADDR : READY=1. On ACK_ADDR=1, capture ADDR_IN and STORE.
//         STORE=0 -> WAIT, load lat counter with RD_LATENCY. STORE=1 -> SWR.
//  WAIT : READY=1, ACK_DATA_MEM=F. Counter decrements. At 0 -> BURST with k=first index.
//         RD_LATENCY=0 skips WAIT entirely.
//  BURST: RDATA=mem[base+k], ACK_DATA_MEM=k. Both are held until ACK_DATA_L1==k.
//         Next cycle present the next k; ACK_DATA_L1!=k is ignored.
//         After the WORDS_PER_LINE-th ack -> DONE, ACK_DATA_MEM=F.
//         Fill of word k takes >=1 cycle (ack may be combinational off ACK_DATA_MEM).
//  SWR  : wait ACK_DATA_L1==0, then write mem[addr]<=WDATA on that edge.
//         ACK_DATA_MEM=0 next cycle, held until VALID=0.
//  DONE : READY=1. VALID=0 -> IDLE, READY=0, ACK_DATA_MEM=F.
//  VALID=0 in any non-IDLE state aborts: IDLE next cycle, no write.
//   A store already written stays written.
//  ACK_ADDR is ignored outside ADDR; ACK_DATA_L1 is ignored outside BURST/SWR.
//  Index k is 3 bits, zero-extended onto ACK_DATA_MEM; 4'hF is never a valid word index.
//  Address arithmetic: base+k, then mod MEM_WORDS (silent wrap at top of memory).
//  Back-to-back: a new VALID after DONE->IDLE needs a fresh ADDR handshake
//   (minimum 1 idle cycle between transactions).
// CONFIGURATION
//  WRAP_BURST_EN defined: critical word first.
//   first k = ADDR_IN[2:0], then (k+1) mod 8 wrapping within the line.
//   ACK_DATA_MEM always carries the true line index.
//  Not defined: first k = 0, ascending 0..7 regardless of ADDR_IN[2:0].
// TESTING
//  1 Reset: RST_N=0 2 cycles mid-BURST -> READY=0, ACK_DATA_MEM=F, BUSY=0.
//    Next VALID restarts at ADDR.
//  2 Fill: mem[0x40+i]=0xA000+i, load ADDR_IN=0x43, RD_LATENCY=2, L1 acks each index
//    -> words 0xA000..0xA007 on idx 0..7. No macro: first word 2 cycles after ACK_ADDR.
//  3 WRAP_BURST_EN: same load -> order idx 3,4,5,6,7,0,1,2 with matching data.
//  4 Store: ADDR_IN=0x105, WDATA=0xDEADBEEF, ACK_DATA_L1=0 -> ACK_DATA_MEM=0 next cycle.
//    Later fill of line 0x100 returns 0xDEADBEEF at idx 5.
//  5 Stall/abort: hold ACK_DATA_L1=F for 5 cycles at idx 2 -> RDATA/idx stable.
//    Drop VALID -> IDLE next cycle.
//  6 Wrap: MEM_WORDS=1024, load ADDR_IN=0x3FF -> reads mem[0x3F8..0x3FF].
//    Load ADDR_IN=0x400 -> reads mem[0x000..0x007].

Source files
------------

// File: rtl/main_memory_ctrl.sv
// Word-addressed main memory serving 8-word line fills and single-word stores to the L1 D-cache.
// Optional `WRAP_BURST_EN: critical-word-first fill order; otherwise fills run ascending from index 0.
module main_memory_ctrl #(
  parameter int unsigned MEM_WORDS      = 1024,
  parameter int unsigned WORDS_PER_LINE = 8,
  parameter int unsigned RD_LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        VALID,
  input  logic        STORE,
  input  logic [31:0] ADDR_IN,
  input  logic        ACK_ADDR,
  input  logic [31:0] WDATA,
  input  logic [3:0]  ACK_DATA_L1,
  output logic        READY,
  output logic [31:0] RDATA,
  output logic [3:0]  ACK_DATA_MEM,
  output logic        BUSY
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned IW = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_BURST,
    S_SWR,
    S_DONE
  } state_t;

  logic [31:0]   mem [MEM_WORDS];

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    lat_q, lat_d;
  logic [IW-1:0] k_q, k_d;
  logic [IW-1:0] beat_q, beat_d;
  logic          wr_done_q, wr_done_d;
  logic          mem_we;
  logic [AW-1:0] rd_idx;
  logic [IW-1:0] first_k;

  // Upper address bits fall away in the modulo-MEM_WORDS indexing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ADDR_IN[31:AW];

`ifdef WRAP_BURST_EN
  assign first_k = ADDR_IN[IW-1:0];
`else
  assign first_k = '0;
`endif

  // Line base has zero low bits, so base+k mod MEM_WORDS is a plain concatenation.
  assign rd_idx = {addr_q[AW-1:IW], k_q};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lat_d     = lat_q;
    k_d       = k_q;
    beat_d    = beat_q;
    wr_done_d = wr_done_q;
    mem_we    = 1'b0;

    if (state_q != S_IDLE && !VALID) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (VALID) state_d = S_ADDR;
        S_ADDR: begin
          if (ACK_ADDR) begin
            addr_d    = ADDR_IN[AW-1:0];
            k_d       = first_k;
            beat_d    = '0;
            wr_done_d = 1'b0;
            if (STORE) begin
              state_d = S_SWR;
            end else if (RD_LATENCY == 0) begin
              state_d = S_BURST;
            end else begin
              state_d = S_WAIT;
              lat_d   = 4'(RD_LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (lat_q == 4'd0) state_d = S_BURST;
          else               lat_d   = lat_q - 4'd1;
        end
        S_BURST: begin
          if (ACK_DATA_L1 == 4'(k_q)) begin
            k_d    = k_q + 1'b1;
            beat_d = beat_q + 1'b1;
            if (beat_q == IW'(WORDS_PER_LINE - 1)) state_d = S_DONE;
          end
        end
        S_SWR: begin
          if (!wr_done_q && ACK_DATA_L1 == 4'h0) begin
            mem_we    = 1'b1;
            wr_done_d = 1'b1;
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      lat_q     <= '0;
      k_q       <= '0;
      beat_q    <= '0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lat_q     <= lat_d;
      k_q       <= k_d;
      beat_q    <= beat_d;
      wr_done_q <= wr_done_d;
    end
  end

  // Storage is never cleared; reset only suppresses the write.
  always_ff @(posedge CLK) begin
    if (RST_N && mem_we) mem[addr_q] <= WDATA;
  end

  always_comb begin
    READY        = (state_q != S_IDLE);
    BUSY         = (state_q != S_IDLE);
    RDATA        = '0;
    ACK_DATA_MEM = 4'hF;
    if (state_q == S_BURST) begin
      RDATA        = mem[rd_idx];
      ACK_DATA_MEM = 4'(k_q);
    end else if (state_q == S_SWR && wr_done_q) begin
      ACK_DATA_MEM = 4'h0;
    end
  end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed plus randomized bench for main_memory_ctrl against a word-array reference model.
module tb_main_memory_ctrl;

  localparam int unsigned MEMW   = 1024;
  localparam int unsigned RD_LAT = 2;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        VALID;
  logic        STORE;
  logic [31:0] ADDR_IN;
  logic        ACK_ADDR;
  logic [31:0] WDATA;
  logic [3:0]  ACK_DATA_L1;
  logic        READY;
  logic [31:0] RDATA;
  logic [3:0]  ACK_DATA_MEM;
  logic        BUSY;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [MEMW];

  main_memory_ctrl #(
    .MEM_WORDS     (MEMW),
    .WORDS_PER_LINE(8),
    .RD_LATENCY    (RD_LAT)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .VALID       (VALID),
    .STORE       (STORE),
    .ADDR_IN     (ADDR_IN),
    .ACK_ADDR    (ACK_ADDR),
    .WDATA       (WDATA),
    .ACK_DATA_L1 (ACK_DATA_L1),
    .READY       (READY),
    .RDATA       (RDATA),
    .ACK_DATA_MEM(ACK_DATA_MEM),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input bit abort);
    VALID = 1'b1;
    STORE = 1'b1;
    step();
    chk("st_addr_ready", 32'(READY), 32'd1);
    ADDR_IN  = addr;
    WDATA    = data;
    ACK_ADDR = 1'b1;
    step();
    ACK_ADDR = 1'b0;
    ADDR_IN  = $urandom;
    chk("st_idx_pre", 32'(ACK_DATA_MEM), 32'hF);
    if (abort) begin
      VALID       = 1'b0;
      ACK_DATA_L1 = 4'h0;
      step();
      ACK_DATA_L1 = 4'hF;
      chk("st_abort_busy", 32'(BUSY), 32'd0);
      chk("st_abort_idx", 32'(ACK_DATA_MEM), 32'hF);
      return;
    end
    ACK_DATA_L1 = 4'h0;
    step();
    ACK_DATA_L1 = 4'hF;
    WDATA       = $urandom;
    chk("st_ack", 32'(ACK_DATA_MEM), 32'h0);
    step();
    chk("st_ack_hold", 32'(ACK_DATA_MEM), 32'h0);
    VALID = 1'b0;
    step();
    chk("st_idle_busy", 32'(BUSY), 32'd0);
    model[addr[9:0]] = data;
  endtask

  // mode: 0 = complete, 1 = drop VALID at stall_k, 2 = reset at stall_k
  task automatic do_load(input logic [31:0] addr, input int stall_k, input int stall_n,
                         input int mode, input bit rnd);
    int          n;
    int          d;
    logic [2:0]  k;
    logic [2:0]  start;
    logic [9:0]  a;
    VALID = 1'b1;
    STORE = 1'b0;
    step();
    chk("ld_addr_ready", 32'(READY), 32'd1);
    chk("ld_addr_busy", 32'(BUSY), 32'd1);
    chk("ld_addr_idx", 32'(ACK_DATA_MEM), 32'hF);
    ADDR_IN  = addr;
    ACK_ADDR = 1'b1;
    step();
    ACK_ADDR = 1'b0;
    ADDR_IN  = $urandom;
    n = 0;
    while (ACK_DATA_MEM === 4'hF && n < 20) begin
      step();
      n++;
    end
    chk("ld_latency", 32'(n), 32'(RD_LAT));
`ifdef WRAP_BURST_EN
    start = addr[2:0];
`else
    start = 3'd0;
`endif
    for (int i = 0; i < 8; i++) begin
      k = start + 3'(i);
      a = {addr[9:3], k};
      if (rnd) begin
        d = int'($urandom_range(0, 2));
        repeat (d) begin
          ACK_DATA_L1 = {1'b0, 3'(k + 3'd1)};
          step();
          chk("ld_wrong_ack_idx", 32'(ACK_DATA_MEM), 32'(k));
        end
      end
      chk("ld_idx", 32'(ACK_DATA_MEM), 32'(k));
      chk("ld_data", RDATA, model[a]);
      if (i == stall_k) begin
        ACK_DATA_L1 = 4'hF;
        repeat (stall_n) begin
          step();
          chk("stall_idx", 32'(ACK_DATA_MEM), 32'(k));
          chk("stall_data", RDATA, model[a]);
        end
        if (mode == 1) begin
          VALID = 1'b0;
          step();
          chk("abort_busy", 32'(BUSY), 32'd0);
          chk("abort_ready", 32'(READY), 32'd0);
          chk("abort_idx", 32'(ACK_DATA_MEM), 32'hF);
          return;
        end
        if (mode == 2) begin
          RST_N = 1'b0;
          VALID = 1'b0;
          step();
          step();
          chk("rst_ready", 32'(READY), 32'd0);
          chk("rst_idx", 32'(ACK_DATA_MEM), 32'hF);
          chk("rst_busy", 32'(BUSY), 32'd0);
          chk("rst_rdata", RDATA, 32'd0);
          RST_N = 1'b1;
          return;
        end
      end
      ACK_DATA_L1 = {1'b0, k};
      step();
      ACK_DATA_L1 = 4'hF;
    end
    chk("done_idx", 32'(ACK_DATA_MEM), 32'hF);
    chk("done_ready", 32'(READY), 32'd1);
    chk("done_busy", 32'(BUSY), 32'd1);
    VALID = 1'b0;
    step();
    chk("post_busy", 32'(BUSY), 32'd0);
  endtask

  initial begin
    logic [31:0] lines [4];
    logic [31:0] ra;
    lines[0] = 32'h040;
    lines[1] = 32'h100;
    lines[2] = 32'h3F8;
    lines[3] = 32'h000;

    RST_N       = 1'b0;
    VALID       = 1'b0;
    STORE       = 1'b0;
    ADDR_IN     = '0;
    ACK_ADDR    = 1'b0;
    WDATA       = '0;
    ACK_DATA_L1 = 4'hF;
    step();
    step();
    chk("reset_ready", 32'(READY), 32'd0);
    chk("reset_rdata", RDATA, 32'd0);
    chk("reset_idx", 32'(ACK_DATA_MEM), 32'hF);
    chk("reset_busy", 32'(BUSY), 32'd0);
    RST_N = 1'b1;
    step();

    for (int i = 0; i < 8; i++) do_store(32'h40 + 32'(i), 32'hA000 + 32'(i), 1'b0);
    for (int l = 1; l < 4; l++)
      for (int i = 0; i < 8; i++) do_store(lines[l] + 32'(i), $urandom, 1'b0);
    do_store(32'h105, 32'hDEADBEEF, 1'b0);

    do_load(32'h43, -1, 0, 0, 1'b0);
    do_load(32'h100, -1, 0, 0, 1'b0);

    do_store(32'h102, 32'h12345678, 1'b1);
    do_load(32'h102, -1, 0, 0, 1'b0);

    do_load(32'h40, 2, 5, 1, 1'b0);
    do_load(32'h45, 3, 1, 2, 1'b0);
    do_load(32'h47, -1, 0, 0, 1'b0);

    do_load(32'h3FF, -1, 0, 0, 1'b0);
    do_load(32'h400, -1, 0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      ra = lines[$urandom_range(0, 3)] + 32'($urandom_range(0, 7)) + (32'($urandom_range(0, 15)) << 10);
      if ($urandom_range(0, 1) == 1) do_store(ra, $urandom, 1'b0);
      ra = lines[$urandom_range(0, 3)] + 32'($urandom_range(0, 7)) + (32'($urandom_range(0, 15)) << 10);
      do_load(ra, -1, 0, 0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
